// File: rtl/sm_accum.sv
// Frame accumulator for the sign-magnitude adder stream: sums beats into a
// clamped two's-complement register and hands out one sign-magnitude total per frame.
module sm_accum #(
    parameter int NUM   = 18,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM:0]     in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    generate
        if (ACC_W < NUM + 2) begin : g_width_check
            $fatal(1, "sm_accum: ACC_W must be at least NUM+2");
        end
    endgenerate

    localparam logic signed [ACC_W:0] MAX_POS = signed'({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] MAX_NEG = -MAX_POS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic signed [ACC_W:0]   acc_r, base_acc_s, beat_s, raw_s, acc_nxt_s;
    logic [CNT_W-1:0]        cnt_r, base_cnt_s, cnt_nxt_s;
    logic                    sat_r, base_sat_s, sat_nxt_s, clamp_s;
    logic                    accept_s, frame_clr_s;
    logic                    out_valid_r, out_sat_r;
    logic [ACC_W-1:0]        out_acc_r;
    logic [CNT_W-1:0]        out_count_r;

    function automatic logic signed [ACC_W:0] sm_to_tc(input logic [NUM:0] sm);
        logic [ACC_W:0] mag;
        mag = {{(ACC_W+1-NUM){1'b0}}, sm[NUM-1:0]};
        if (sm[NUM]) begin
            return signed'(~mag + {{ACC_W{1'b0}}, 1'b1});
        end else begin
            return signed'(mag);
        end
    endfunction

    // The clamp bounds |v| below 2^(ACC_W-1), so the low bits alone carry the magnitude.
    function automatic logic [ACC_W-1:0] tc_to_sm(input logic sgn, input logic [ACC_W-2:0] low);
        logic [ACC_W-2:0] mag;
        if (sgn) begin
            mag = ~low + {{(ACC_W-2){1'b0}}, 1'b1};
        end else begin
            mag = low;
        end
        return {sgn, mag};
    endfunction

    assign in_ready  = ~out_valid_r | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_count = out_count_r;
    assign out_sat   = out_sat_r;

    // Beat datapath: a beat taken while a result is pending starts a fresh frame from zero.
    always_comb begin
        base_acc_s = {(ACC_W+1){1'b0}};
        base_cnt_s = {CNT_W{1'b0}};
        base_sat_s = 1'b0;
        if (state_r != DONE) begin
            base_acc_s = acc_r;
            base_cnt_s = cnt_r;
            base_sat_s = sat_r;
        end else begin
            base_sat_s = 1'b0;
        end
        beat_s = sm_to_tc(in_sum);
        raw_s  = base_acc_s + beat_s;
        if (raw_s > MAX_POS) begin
            acc_nxt_s = MAX_POS;
            clamp_s   = 1'b1;
        end else if (raw_s < MAX_NEG) begin
            acc_nxt_s = MAX_NEG;
            clamp_s   = 1'b1;
        end else begin
            acc_nxt_s = raw_s;
            clamp_s   = 1'b0;
        end
        if (base_cnt_s == {CNT_W{1'b1}}) begin
            cnt_nxt_s = base_cnt_s;
        end else begin
            cnt_nxt_s = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        sat_nxt_s = base_sat_s | clamp_s;
    end

    // Frame state machine: next state and the frame-clear strobe on a result drain.
    always_comb begin
        state_nxt_s = state_r;
        frame_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = in_last ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && in_last) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready && accept_s) begin
                    state_nxt_s = in_last ? DONE : RUN;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                    frame_clr_s = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                frame_clr_s = 1'b1;
            end
        endcase
    end

    // State and running frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {(ACC_W+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                acc_r <= acc_nxt_s;
                cnt_r <= cnt_nxt_s;
                sat_r <= sat_nxt_s;
            end else if (frame_clr_s) begin
                acc_r <= {(ACC_W+1){1'b0}};
                cnt_r <= {CNT_W{1'b0}};
                sat_r <= 1'b0;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Result registers, loaded with the post-add totals when the last beat lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_acc_r   <= {ACC_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == DONE);
            if (accept_s && in_last) begin
                out_acc_r   <= tc_to_sm(acc_nxt_s[ACC_W], acc_nxt_s[ACC_W-2:0]);
                out_count_r <= cnt_nxt_s;
                out_sat_r   <= sat_nxt_s;
            end else begin
                out_acc_r <= out_acc_r;
            end
        end
    end

endmodule

// File: tb/tb_sm_accum.sv
// Bench for sm_accum: directed frames with literal totals, then random traffic
// checked every cycle against a frame-level arithmetic model.
module tb_sm_accum;

    localparam int    NUM   = 18;
    localparam int    ACC_W = 24;
    localparam int    CNT_W = 8;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NUM:0]     in_sum;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    sm_accum #(.NUM(NUM), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // frame-level model state
    longint           fsum;
    int               fcnt;
    bit               fsat;
    bit               exp_valid;
    bit               exp_fresh;
    logic [ACC_W-1:0] exp_acc;
    int               exp_cnt;
    bit               exp_sat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_update();
        longint v;
        bit     take;
        if (rst) begin
            fsum = 0; fcnt = 0; fsat = 0;
            exp_valid = 0; exp_fresh = 1;
            exp_acc = '0; exp_cnt = 0; exp_sat = 0;
        end else begin
            take = in_valid && (!exp_valid || out_ready);
            if (exp_valid && out_ready) exp_valid = 0;
            if (take) begin
                v = longint'(in_sum[NUM-1:0]);
                if (in_sum[NUM]) v = -v;
                fsum = fsum + v;
                if (fsum > MAXV) begin
                    fsum = MAXV; fsat = 1;
                end else if (fsum < -MAXV) begin
                    fsum = -MAXV; fsat = 1;
                end
                if (fcnt < (1 << CNT_W) - 1) fcnt++;
                if (in_last) begin
                    exp_valid = 1;
                    exp_fresh = 0;
                    if (fsum < 0) exp_acc = (ACC_W'(1) << (ACC_W-1)) | ACC_W'(-fsum);
                    else          exp_acc = ACC_W'(fsum);
                    exp_cnt = fcnt;
                    exp_sat = fsat;
                    fsum = 0; fcnt = 0; fsat = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the rising edge.
    task automatic cycle(input logic r, input logic v, input logic [NUM:0] s,
                         input logic l, input logic o);
        rst = r; in_valid = v; in_sum = s; in_last = l; out_ready = o;
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic expect_lit(input string nm, input logic ev, input logic [ACC_W-1:0] ea,
                              input int ec, input logic es);
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'(ev));
        chk({nm, "_acc"},   32'(out_acc),   32'(ea));
        chk({nm, "_count"}, 32'(out_count), 32'(ec));
        chk({nm, "_sat"},   32'(out_sat),   32'(es));
    endtask

    // Single compare process: DUT against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("in_ready",  32'(in_ready),  32'(!exp_valid || out_ready));
            if (exp_valid || exp_fresh) begin
                chk("out_acc",   32'(out_acc),   32'(exp_acc));
                chk("out_count", 32'(out_count), 32'(exp_cnt));
                chk("out_sat",   32'(out_sat),   32'(exp_sat));
            end
        end
    end

    initial begin
        logic [NUM:0] s;
        logic         sg;
        int           phase_lastdiv;
        rst = 1'b1; in_valid = 1'b1; in_sum = 19'h00005; in_last = 1'b0; out_ready = 1'b1;

        // reset held two cycles with a valid beat present
        cycle(1'b1, 1'b1, 19'h00005, 1'b0, 1'b1);
        chk_en = 1'b1;
        cycle(1'b1, 1'b1, 19'h00005, 1'b0, 1'b1);
        expect_lit("reset", 1'b0, 24'h000000, 0, 1'b0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // basic three-beat frame: 5 - 12 + 3 = -4
        cycle(1'b0, 1'b1, 19'h00005, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 19'h4000C, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 19'h00003, 1'b1, 1'b0);
        expect_lit("basic", 1'b1, 24'h800004, 3, 1'b0);

        // backpressure: result held, no beat accepted
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 19'h00009, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        expect_lit("bp_hold", 1'b1, 24'h800004, 3, 1'b0);
        // drain and start a single-beat frame in the same cycle
        cycle(1'b0, 1'b1, 19'h00007, 1'b1, 1'b1);
        expect_lit("b2b", 1'b1, 24'h000007, 1, 1'b0);
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);

        // positive saturation over 33 full-scale beats
        for (int i = 0; i < 33; i++) cycle(1'b0, 1'b1, 19'h3FFFF, (i == 32), 1'b0);
        expect_lit("sat_pos", 1'b1, 24'h7FFFFF, 33, 1'b1);
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);

        // negative clamp, then a later beat pulls the total back in
        for (int i = 0; i < 34; i++) cycle(1'b0, 1'b1, (i == 33) ? 19'h3FFFF : 19'h7FFFF, (i == 33), 1'b0);
        expect_lit("sat_pullback", 1'b1, 24'hFC0000, 34, 1'b1);
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);

        // negative zero
        cycle(1'b0, 1'b1, 19'h40000, 1'b1, 1'b1);
        expect_lit("negzero", 1'b1, 24'h000000, 1, 1'b0);
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);

        // beat counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 19'h00000, (i == 299), 1'b1);
        expect_lit("cnt_sat", 1'b1, 24'h000000, 255, 1'b0);
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);

        // reset mid-frame discards the partial sum
        cycle(1'b0, 1'b1, 19'h00064, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 19'h000C8, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 19'h00000, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 19'h00001, 1'b1, 1'b1);
        expect_lit("rst_mid", 1'b1, 24'h000001, 1, 1'b0);

        // random traffic: short frames first, then long biased frames to reach the clamps
        for (int i = 0; i < 4000; i++) begin
            phase_lastdiv = (i < 2000) ? 6 : 48;
            s = 19'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                sg = (i < 2000) ? s[NUM] : ($urandom_range(0, 3) != 0);
                s = {sg, 18'h3FFFF - 18'($urandom_range(0, 4095))};
            end
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), s,
                  ($urandom_range(0, phase_lastdiv) == 0), ($urandom_range(0, 3) != 0));
        end
        cycle(1'b0, 1'b0, 19'h00000, 1'b0, 1'b1);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_accum.md
Name: sm_accum

Overview:
Downstream consumer of the sign-magnitude add/subtract stage. It takes the (NUM+1)-bit sign-magnitude sum stream and accumulates beats into a wider saturating accumulator, one frame at a time. A frame is terminated by in_last. When the frame ends, the block presents the frame total in sign-magnitude form, together with a beat count and a saturation flag, over a valid/ready output handshake.

Parameters:
NUM, 18, operand width of the upstream adder; input sum is NUM+1 bits (bit NUM = sign, [NUM-1:0] = magnitude)
ACC_W, 24, output width; sign-magnitude (bit ACC_W-1 = sign); must be >= NUM+2 (elaboration-time check, fatal otherwise)
CNT_W, 8, beat-counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_sum  in  NUM+1  sign-magnitude sum from adder
in_last  in  1  beat is the last of its frame
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  frame total, sign-magnitude
out_count  out  CNT_W  beats in frame, saturating
out_sat  out  1  saturation occurred in this frame

Behaviour:
- Reset: all registers clear on the first rising clk edge with rst=1. Values after reset:
  - out_valid=0, out_acc=0, out_count=0, out_sat=0
  - internal accumulator=0, state=IDLE
  - in_ready=1
- Reset mid-frame discards the partial frame and any pending result.
- Handshakes:
  - in_ready = !out_valid | out_ready (combinational).
  - A beat is accepted when in_valid & in_ready.
  - The output transfers when out_valid & out_ready.
  - out_acc, out_count and out_sat hold stable while out_valid=1 and out_ready=0.
- Input conversion:
  - in_sum is converted to two's complement: magnitude, negated if the sign is set.
  - Negative zero (sign=1, magnitude=0) equals 0.
- Accumulation:
  - Internal register is ACC_W+1 bits two's complement.
  - Per accepted beat: next = clamp(acc + in), clamped to ±(2^(ACC_W-1)-1).
  - Clamping happens every beat, so a later beat can pull the total back from the limit.
  - If a clamp engages, a sticky frame-sat flag is set.
- Beat count: increments per accepted beat and saturates at 2^CNT_W-1.
- States:
  - IDLE: accumulator=0, count=0, sat=0. Accepted beat with in_last=0 → RUN. Accepted beat with in_last=1 → DONE.
  - RUN: accepted beat adds. If in_last=1 → DONE.
  - DONE: out_valid=1. Outputs are loaded on entry from the post-add values, so the last beat is included.
  - On leaving DONE, frame state (accumulator, count, sat) clears before any new beat is applied.
  - In DONE with out_ready=1 and a beat accepted the same cycle: a new frame starts from zero with that beat, going to RUN, or back to DONE if in_last=1. The new result loads next cycle and out_valid stays 1.
  - In DONE with out_ready=1 and no beat: → IDLE, out_valid=0.
- Latency: the result is visible (out_valid=1) on the cycle after the last beat is accepted.
- Output encoding:
  - out_acc = {sign, |total|}.
  - A zero total always has sign=0; negative zero is never output.
  - Magnitude never exceeds 2^(ACC_W-1)-1.
- Throughput: one beat per cycle, including back-to-back single-beat frames when out_ready=1.
- Inputs in_sum and in_last are ignored when a beat is not accepted.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, out_acc=0, out_count=0, out_sat=0, in_ready=1; no beat counted.
- Basic frame (defaults): beats +5 (19'h00005), −12 (19'h4000C), +3 with in_last → one cycle later out_valid=1, out_acc=24'h800004, out_count=3, out_sat=0.
- Saturation: 33 beats of +262143 (19'h3FFFF), last on the 33rd → out_acc=24'h7FFFFF, out_count=33, out_sat=1.
- Backpressure/back-to-back: hold out_ready=0 with a result pending → in_ready=0, outputs stable for 5 cycles. Then out_ready=1 with beat +7 and in_last=1 in the same cycle → next cycle out_valid=1, out_acc=24'h000007, out_count=1.
- Negative zero: single beat 19'h40000 with in_last → out_acc=24'h000000, out_count=1, out_sat=0.
- Reset mid-frame: beats +100, +200, then rst for 1 cycle, then +1 with in_last → out_acc=24'h000001, out_count=1.
